// File: rtl/cdh_event_fifo_pkg.sv
// Shared trigger-side definitions for the CDH event buffer: word geometry and
// the sender FSM encoding.
package cdh_event_fifo_pkg;

  localparam int unsigned CDH_W      = 32;
  localparam int unsigned NWORDS_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/cdh_slot_ram.sv
// Event storage: DEPTH slots of NWORDS CDH words. A whole slot is written in
// one cycle; a single word is read through an output register.
module cdh_slot_ram
  import cdh_event_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NWORDS = NWORDS_DEF
) (
  input  logic                              gclk_40m,
  input  logic                              wr_en_i,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]   wr_slot_i,
  input  logic [NWORDS*CDH_W-1:0]           wr_data_i,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0]   rd_slot_i,
  input  logic [((NWORDS > 1) ? $clog2(NWORDS) : 1)-1:0] rd_word_i,
  output logic [CDH_W-1:0]                  rd_data_o
);
  localparam int unsigned WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [CDH_W-1:0] mem_q [DEPTH][NWORDS];
  logic [CDH_W-1:0] rd_data_q;

  always_ff @(posedge gclk_40m) begin
    if (wr_en_i) begin
      for (int unsigned w = 0; w < NWORDS; w++) begin
        mem_q[wr_slot_i][WW'(w)] <= wr_data_i[w*CDH_W +: CDH_W];
      end
    end
    rd_data_q <= mem_q[rd_slot_i][rd_word_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cdh_event_fifo.sv
// Buffers captured CDH events and streams them word by word to the DDL sender
// with sof/eof framing; counts captures dropped while full.
module cdh_event_fifo
  import cdh_event_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NWORDS = NWORDS_DEF
) (
  input  logic                     gclk_40m,
  input  logic                     reset,
  input  logic                     cdh_capture,
  input  logic [NWORDS*CDH_W-1:0]  cdh_bus,
  input  logic                     flush,
  input  logic                     tx_ready,
  output logic [CDH_W-1:0]         tx_data,
  output logic                     tx_valid,
  output logic                     tx_sof,
  output logic                     tx_eof,
  output logic [3:0]               ev_count,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     busy_req,
  output logic [15:0]              ovf_cnt
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WW-1:0] LAST_W = WW'(NWORDS - 1);

  fsm_state_t       state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WW-1:0]    widx_q, widx_d;
  logic [CDH_W-1:0] tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d, tx_sof_q, tx_sof_d, tx_eof_q, tx_eof_d;
  logic [15:0]      ovf_q, ovf_d;

  logic             full, hs, last, accept, drop, wr_en;
  logic [WW-1:0]    ram_rd_word;
  logic [CDH_W-1:0] ram_rdata;

  cdh_slot_ram #(.DEPTH(DEPTH), .NWORDS(NWORDS)) u_ram (
    .gclk_40m  (gclk_40m),
    .wr_en_i   (wr_en),
    .wr_slot_i (wr_ptr_q),
    .wr_data_i (cdh_bus),
    .rd_slot_i (rd_ptr_d),
    .rd_word_i (ram_rd_word),
    .rd_data_o (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    widx_d     = widx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_sof_d   = tx_sof_q;
    tx_eof_d   = tx_eof_q;
    ovf_d      = ovf_q;

    full   = (cnt_q == 4'(DEPTH));
    hs     = tx_valid_q && tx_ready;
    last   = (state_q == ST_SEND) && hs && (widx_q == LAST_W);
    // The slot being drained frees this cycle, so a capture while full still fits.
    accept = cdh_capture && (!full || last);
    drop   = cdh_capture && full && !last;
    wr_en  = accept && !flush;

    unique case (state_q)
      ST_IDLE: if (cnt_q != 4'd0) state_d = ST_LOAD;
      ST_LOAD: begin
        tx_data_d  = ram_rdata;
        tx_valid_d = 1'b1;
        tx_sof_d   = 1'b1;
        tx_eof_d   = (NWORDS == 1);
        state_d    = ST_SEND;
      end
      ST_SEND: if (hs) begin
        if (last) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          tx_sof_d   = 1'b0;
          tx_eof_d   = 1'b0;
          widx_d     = '0;
          rd_ptr_d   = rd_ptr_q + PW'(1);
        end else begin
          widx_d    = widx_q + WW'(1);
          tx_data_d = ram_rdata;
          tx_sof_d  = 1'b0;
          tx_eof_d  = (widx_q + WW'(1) == LAST_W);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) wr_ptr_d = wr_ptr_q + PW'(1);
    cnt_d = cnt_q + {3'b000, accept} - {3'b000, last};
    if (drop && !flush && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;

    if (flush) begin
      state_d    = ST_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      widx_d     = '0;
      tx_valid_d = 1'b0;
      tx_sof_d   = 1'b0;
      tx_eof_d   = 1'b0;
    end

    // Read one word ahead so the registered RAM output already holds the next word.
    ram_rd_word = '0;
    if (state_d == ST_SEND && widx_d != LAST_W) ram_rd_word = widx_d + WW'(1);
  end

  always_ff @(posedge gclk_40m) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      widx_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_sof_q   <= 1'b0;
      tx_eof_q   <= 1'b0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_sof_q   <= tx_sof_d;
      tx_eof_q   <= tx_eof_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign tx_sof     = tx_sof_q;
  assign tx_eof     = tx_eof_q;
  assign ev_count   = cnt_q;
  assign fifo_full  = (cnt_q == 4'(DEPTH));
  assign fifo_empty = (cnt_q == 4'd0);
  assign busy_req   = (cnt_q >= 4'(DEPTH - 1));
  assign ovf_cnt    = ovf_q;

endmodule
